dmem_sram_responder: RTL and testbench



---
 rtl/dmem_sram_responder_if.sv | 31 +++
 rtl/dmem_sram_responder.sv | 109 ++++++++++
 tb/tb_dmem_sram_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram_responder_if
// Purpose  : load/store request and in-order response bus of the data SRAM
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        hold;
  logic        data_stall;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        data_err;

  modport master (
    output req, wr, size, addr, wstrb, wdata, hold, data_stall,
    input  addr_ok, data_ok, rdata, data_err
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata, hold, data_stall,
    output addr_ok, data_ok, rdata, data_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram_responder
// Purpose  : byte-lane SRAM with fixed-latency, in-order, stallable responses
// Revision : 1.0 - initial release
// ============================================================================
module dmem_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int QDEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_sram_responder_if.slave bus
);
  localparam int              c_PW       = $clog2(QDEPTH);
  localparam int              c_WORDS    = 1 << ADDR_W;
  localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
  localparam logic [c_PW:0]   c_CNT_ONE  = (c_PW+1)'(1);
  localparam logic [c_PW:0]   c_CNT_FULL = (c_PW+1)'(QDEPTH);
  localparam logic [1:0]      c_CD_INIT  = 2'(LATENCY - 1);

  logic [ADDR_W-1:0] w_idx;
  logic              w_err;
  logic              w_accept;
  logic              w_emit;
  logic [31:0]       w_rword;
  logic [31:0]       w_push_data;
  logic              w_unused_addr_hi;

  logic [c_PW-1:0]   r_wptr;
  logic [c_PW-1:0]   r_rptr;
  logic [c_PW:0]     r_count;
  logic [31:0]       r_q_data [QDEPTH];
  logic              r_q_err  [QDEPTH];
  logic [1:0]        r_q_cd   [QDEPTH];

  // Upper address bits are ignored on purpose: the memory aliases.
  assign w_idx            = bus.addr[ADDR_W+1:2];
  assign w_unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  always_comb begin
    w_err = 1'b0;
    case (bus.size)
      2'd1:    w_err = bus.addr[0];
      2'd2:    w_err = |bus.addr[1:0];
      2'd3:    w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
  end

  assign bus.addr_ok = !rst && !bus.hold && (r_count < c_CNT_FULL);
  assign w_accept    = bus.req && bus.addr_ok;
  assign w_emit      = !rst && (r_count != '0) && (r_q_cd[r_rptr] == 2'd0)
                       && !bus.data_stall;

  // One byte-wide array per lane keeps each lane write in a single process.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [c_WORDS];

    always_ff @(posedge clk) begin
      if (w_accept && bus.wr && !w_err && bus.wstrb[gi]) begin
        r_mem[w_idx] <= bus.wdata[8*gi +: 8];
      end
    end

    assign w_rword[8*gi +: 8] = r_mem[w_idx];
  end

  assign w_push_data = (bus.wr || w_err) ? 32'h0 : w_rword;

  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (r_q_cd[i] != 2'd0) begin
        r_q_cd[i] <= r_q_cd[i] - 2'd1;
      end
    end
    if (w_accept) begin
      r_q_data[r_wptr] <= w_push_data;
      r_q_err[r_wptr]  <= w_err;
      r_q_cd[r_wptr]   <= c_CD_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_emit) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      if (w_accept && !w_emit) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_accept && w_emit) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  assign bus.data_ok  = w_emit;
  assign bus.rdata    = w_emit ? r_q_data[r_rptr] : 32'h0;
  assign bus.data_err = w_emit && r_q_err[r_rptr];
endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sram_responder
// Purpose  : self-checking bench, LATENCY=1 and LATENCY=3 units vs queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_sram_responder;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] ready;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_v, req_v, wr_v, hold_v, stall_v;
  logic [1:0][1:0]  size_v;
  logic [1:0][31:0] addr_v, wdata_v;
  logic [1:0][3:0]  wstrb_v;
  wire  [1:0]       aok_v, dok_v, err_v;
  wire  [1:0][31:0] rd_v;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_unit
    localparam int LAT = (g == 0) ? 1 : 3;

    dmem_sram_responder_if bus ();
    assign bus.req        = req_v[g];
    assign bus.wr         = wr_v[g];
    assign bus.size       = size_v[g];
    assign bus.addr       = addr_v[g];
    assign bus.wstrb      = wstrb_v[g];
    assign bus.wdata      = wdata_v[g];
    assign bus.hold       = hold_v[g];
    assign bus.data_stall = stall_v[g];
    assign aok_v[g]       = bus.addr_ok;
    assign dok_v[g]       = bus.data_ok;
    assign rd_v[g]        = bus.rdata;
    assign err_v[g]       = bus.data_err;

    dmem_sram_responder #(.ADDR_W(10), .LATENCY(LAT), .QDEPTH(4)) u_dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus)
    );

    // Reference: queue of pending responses, each tagged with its earliest emit cycle.
    resp_t       q[$];
    logic [31:0] mm [int unsigned];
    logic [31:0] cyc = 0;
    logic        acc = 1'b0;
    logic        emt = 1'b0;

    always @(negedge clk) begin : b_chk
      logic        exp_aok, exp_dok, exp_err;
      logic [31:0] exp_rd;
      exp_aok = !rst_v[g] && !hold_v[g] && (q.size() < 4);
      exp_dok = 1'b0;
      exp_rd  = 32'h0;
      exp_err = 1'b0;
      if (!rst_v[g] && !stall_v[g] && q.size() > 0) begin
        if (q[0].ready <= cyc) begin
          exp_dok = 1'b1;
          exp_rd  = q[0].rdata;
          exp_err = q[0].err;
        end
      end
      if (cyc > 0) begin
        check_eq($sformatf("u%0d addr_ok c%0d", g, cyc), aok_v[g], exp_aok);
        check_eq($sformatf("u%0d data_ok c%0d", g, cyc), dok_v[g], exp_dok);
        check_eq($sformatf("u%0d rdata c%0d", g, cyc), rd_v[g], exp_rd);
        check_eq($sformatf("u%0d data_err c%0d", g, cyc), err_v[g], exp_err);
      end
      acc <= req_v[g] && exp_aok;
      emt <= exp_dok;
    end

    always @(posedge clk) begin : b_upd
      resp_t       e;
      int unsigned idx;
      logic [31:0] w;
      logic        bad;
      if (rst_v[g]) begin
        q.delete();
      end else begin
        if (emt) void'(q.pop_front());
        if (acc) begin
          idx = (addr_v[g] / 4) % 1024;
          bad = (size_v[g] == 2'd3) || ((addr_v[g] % (32'd1 << size_v[g])) != 0);
          w   = mm.exists(idx) ? mm[idx] : 32'h0;
          e.err   = bad;
          e.rdata = (wr_v[g] || bad) ? 32'h0 : w;
          e.ready = cyc + LAT;
          if (wr_v[g] && !bad) begin
            for (int i = 0; i < 4; i++) begin
              if (wstrb_v[g][i]) w[8*i +: 8] = wdata_v[g][8*i +: 8];
            end
            mm[idx] = w;
          end
          q.push_back(e);
        end
      end
      cyc <= cyc + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input int u, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] st, input logic [31:0] wd);
    int k = 0;
    req_v[u] = 1'b1; wr_v[u] = w; size_v[u] = sz; addr_v[u] = a;
    wstrb_v[u] = st; wdata_v[u] = wd;
    while (1) begin
      @(negedge clk);
      if (aok_v[u]) break;
      k++;
      if (k > 100) begin
        check_eq("accept_timeout", aok_v[u], 32'd1);
        break;
      end
      step();
    end
    step();
    req_v[u] = 1'b0;
  endtask

  task automatic wait_resp(input int u, output logic [31:0] rd, output logic er);
    logic got = 1'b0;
    rd = 32'h0;
    er = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (dok_v[u]) begin
        rd = rd_v[u];
        er = err_v[u];
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) check_eq("resp_timeout", got, 32'd1);
    step();
  endtask

  task automatic xfer(input int u, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [3:0] st, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        er;
    idle(4);
    issue(u, w, sz, a, st, wd);
    wait_resp(u, rd, er);
    check_eq({tag, " rdata"}, rd, exp_rd);
    check_eq({tag, " err"}, er, exp_err);
  endtask

  task automatic rand_run(input int u, input int ncyc);
    logic acc;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      acc = req_v[u] && aok_v[u];
      step();
      if (!req_v[u] || acc) begin
        req_v[u]   = ($urandom_range(3) != 0);
        wr_v[u]    = 1'($urandom_range(1));
        size_v[u]  = 2'($urandom_range(3));
        addr_v[u]  = ($urandom & 32'hFFFF_F000) | ((32'h20 + $urandom_range(7)) << 2)
                     | 32'($urandom_range(3));
        wstrb_v[u] = 4'($urandom);
        wdata_v[u] = $urandom;
      end
      hold_v[u]  = ($urandom_range(9) == 0);
      stall_v[u] = ($urandom_range(3) == 0);
    end
    req_v[u] = 1'b0; hold_v[u] = 1'b0; stall_v[u] = 1'b0;
    idle(10);
  endtask

  initial begin : b_main
    int n, ndok;
    logic [31:0] rd;
    logic er;
    rst_v = 2'b11; req_v = '0; wr_v = '0; hold_v = '0; stall_v = '0;
    size_v = '0; addr_v = '0; wdata_v = '0; wstrb_v = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_v = 2'b00;

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 8; i++) begin
        xfer(u, 1'b1, 2'd2, 32'h80 + 4*i, 4'hF, 32'h1000_0000 * (u + 1) + i, 32'h0, 1'b0, "preload");
      end
    end

    // Back-to-back word store and load.
    idle(4);
    issue(0, 1'b1, 2'd2, 32'h10, 4'hF, 32'hDEAD_BEEF);
    issue(0, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
    wait_resp(0, rd, er);
    check_eq("st_ld rdata", rd, 32'hDEAD_BEEF);
    check_eq("st_ld err", er, 1'b0);

    xfer(0, 1'b1, 2'd2, 32'h10, 4'hF, 32'h1122_3344, 32'h0, 1'b0, "word_store");
    xfer(0, 1'b1, 2'd0, 32'h13, 4'h8, 32'h5A00_0000, 32'h0, 1'b0, "byte_store");
    xfer(0, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'h5A22_3344, 1'b0, "byte_merge");
    xfer(0, 1'b0, 2'd1, 32'h21, 4'h0, 32'h0, 32'h0, 1'b1, "half_misaligned");
    xfer(0, 1'b0, 2'd3, 32'h10, 4'h0, 32'h0, 32'h0, 1'b1, "size3_load");
    xfer(0, 1'b1, 2'd2, 32'h12, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, "bad_store");
    xfer(0, 1'b0, 2'd2, 32'hABCD_E010, 4'h0, 32'h0, 32'h5A22_3344, 1'b0, "alias_after_bad");

    // Five loads under stall on the LATENCY=3 unit.
    idle(4);
    stall_v[1] = 1'b1; n = 0; ndok = 0;
    req_v[1] = 1'b1; wr_v[1] = 1'b0; size_v[1] = 2'd2; addr_v[1] = 32'h80;
    repeat (8) begin
      @(negedge clk);
      if (req_v[1] && aok_v[1]) n++;
      step();
      if (n < 5) addr_v[1] = 32'h80 + 4*n; else req_v[1] = 1'b0;
    end
    check_eq("stall_accepted", n, 32'd4);
    @(negedge clk);
    check_eq("stall_full_aok", aok_v[1], 1'b0);
    step();
    stall_v[1] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (req_v[1] && aok_v[1]) n++;
      if (dok_v[1]) ndok++;
      step();
      if (n < 5) addr_v[1] = 32'h80 + 4*n; else req_v[1] = 1'b0;
    end
    check_eq("stall_total_accepted", n, 32'd5);
    check_eq("stall_responses", ndok, 32'd5);

    // Reset with two responses pending.
    xfer(1, 1'b1, 2'd2, 32'h40, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, "pre_rst_store");
    idle(4);
    issue(1, 1'b0, 2'd2, 32'h80, 4'h0, 32'h0);
    issue(1, 1'b0, 2'd2, 32'h84, 4'h0, 32'h0);
    rst_v[1] = 1'b1;
    @(negedge clk);
    check_eq("rst_aok", aok_v[1], 1'b0);
    check_eq("rst_dok", dok_v[1], 1'b0);
    step();
    rst_v[1] = 1'b0;
    @(negedge clk);
    check_eq("post_rst_aok", aok_v[1], 1'b1);
    ndok = 0;
    repeat (6) begin
      @(negedge clk);
      if (dok_v[1]) ndok++;
      step();
    end
    check_eq("post_rst_no_dok", ndok, 32'd0);
    xfer(1, 1'b0, 2'd2, 32'h40, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "post_rst_load");

    // hold blocks acceptance until released.
    idle(4);
    hold_v[0] = 1'b1;
    req_v[0] = 1'b1; wr_v[0] = 1'b0; size_v[0] = 2'd2; addr_v[0] = 32'h10;
    repeat (3) begin
      @(negedge clk);
      check_eq("hold_aok", aok_v[0], 1'b0);
      step();
    end
    hold_v[0] = 1'b0;
    @(negedge clk);
    check_eq("hold_release_aok", aok_v[0], 1'b1);
    step();
    req_v[0] = 1'b0;
    wait_resp(0, rd, er);
    check_eq("hold_load rdata", rd, 32'h5A22_3344);

    rand_run(0, 600);
    rand_run(1, 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : b_watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
